// File: rtl/safe_pkg.sv
// Shared definitions for the digital safe: state encodings, key codes, default password.
package safe_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned KEY_W     = 4;
    localparam int unsigned PW_W      = 16;
    localparam int unsigned TMR_W     = 16;
    localparam int unsigned DCNT_W    = 3;
    localparam int unsigned FCNT_W    = 2;
    localparam int unsigned PW_DIGITS = 4;

    // Encodings are shared with feedback_controller; do not renumber.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 4'b0000,
        S_D1        = 4'b0001,
        S_D2        = 4'b0010,
        S_D3        = 4'b0011,
        S_FULL      = 4'b0100,
        S_NEWPW     = 4'b0101,
        S_SAVED     = 4'b0110,
        S_UNLOCK    = 4'b0111,
        S_FAIL      = 4'b1000,
        S_LOCKOUT   = 4'b1001,
        S_EMERGENCY = 4'b1010
    } state_t;

    localparam logic [KEY_W-1:0] KEY_STAR  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_ENTER = 4'hB;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hC;

    localparam logic [PW_W-1:0] SAFE_DEFAULT_PW = 16'h1234;

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= KEY_W'(9);
    endfunction

    // Entry-state progression as digits arrive; FULL is absorbing.
    function automatic state_t entry_advance(input state_t s);
        case (s)
            S_IDLE:  return S_D1;
            S_D1:    return S_D2;
            S_D2:    return S_D3;
            default: return S_FULL;
        endcase
    endfunction

endpackage

// File: rtl/safe_ms_timer.sv
// Millisecond down-counter: load N-1, count down while run is high, expired when zero.
module safe_ms_timer
    import safe_pkg::*;
(
    input  logic             clk_1khz,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_value,
    input  logic             run,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    // expired is kept registered alongside count so it always equals (count == 0).
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b1;
        end else if (load) begin
            count   <= load_value;
            expired <= (load_value == '0);
        end else if (run && (count != '0)) begin
            count   <= count - TMR_W'(1);
            expired <= (count == TMR_W'(1));
        end
    end

endmodule

// File: rtl/safe_lock_fsm.sv
// Main safe control FSM: password entry, fail counting, lockout, emergency egress.
// Optional password change via `*` in UNLOCK is enabled by defining SAFE_PWCHANGE_EN.
module safe_lock_fsm
    import safe_pkg::*;
#(
    parameter logic [PW_W-1:0] DEFAULT_PW = SAFE_DEFAULT_PW,
    parameter int unsigned     MAX_FAIL   = 3,
    parameter int unsigned     UNLOCK_MS  = 5000,
    parameter int unsigned     FAIL_MS    = 1000,
    parameter int unsigned     LOCKOUT_MS = 30000
) (
    input  logic               clk_1khz,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               emergency_in,
    output logic [STATE_W-1:0] state,
    output logic               door_unlock,
    output logic [FCNT_W-1:0]  fail_count,
    output logic [DCNT_W-1:0]  digit_count
);

    state_t             cur, nxt;
    logic [PW_W-1:0]    entry, entry_nxt;
    logic [PW_W-1:0]    pw;
    logic [DCNT_W-1:0]  dcnt_nxt;
    logic [FCNT_W-1:0]  fcnt_nxt;
    logic               tmr_load, tmr_run, tmr_expired;
    logic [TMR_W-1:0]   tmr_value;
    logic               key_digit, key_enter, key_clear;
    logic               pw_match;
`ifdef SAFE_PWCHANGE_EN
    logic               key_star, pw_we;
`endif

    assign state = cur;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_enter = key_valid && (key_code == KEY_ENTER);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    assign pw_match  = (digit_count == DCNT_W'(PW_DIGITS)) && (entry == pw);
`ifdef SAFE_PWCHANGE_EN
    assign key_star  = key_valid && (key_code == KEY_STAR);
`else
    assign pw = DEFAULT_PW;
`endif

    // The timer only counts in states with a dwell; NEWPW leaves it frozen.
    assign tmr_run = (cur == S_UNLOCK) || (cur == S_FAIL) ||
                     (cur == S_LOCKOUT) || (cur == S_SAVED);

    safe_ms_timer u_timer (
        .clk_1khz   (clk_1khz),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .run        (tmr_run),
        .expired    (tmr_expired)
    );

    // Next-state and datapath decisions; emergency has absolute priority.
    always_comb begin
        nxt       = cur;
        entry_nxt = entry;
        dcnt_nxt  = digit_count;
        fcnt_nxt  = fail_count;
        tmr_load  = 1'b0;
        tmr_value = '0;
`ifdef SAFE_PWCHANGE_EN
        pw_we     = 1'b0;
`endif
        if (emergency_in) begin
            nxt = S_EMERGENCY;
        end else begin
            case (cur)
                S_IDLE, S_D1, S_D2, S_D3, S_FULL: begin
                    if (key_enter) begin
                        entry_nxt = '0;
                        dcnt_nxt  = '0;
                        tmr_load  = 1'b1;
                        if (pw_match) begin
                            nxt       = S_UNLOCK;
                            fcnt_nxt  = '0;
                            tmr_value = TMR_W'(UNLOCK_MS - 1);
                        end else begin
                            nxt       = S_FAIL;
                            fcnt_nxt  = (fail_count == '1) ? fail_count
                                                           : fail_count + FCNT_W'(1);
                            tmr_value = TMR_W'(FAIL_MS - 1);
                        end
                    end else if (key_clear) begin
                        nxt       = S_IDLE;
                        entry_nxt = '0;
                        dcnt_nxt  = '0;
                    end else if (key_digit && (cur != S_FULL)) begin
                        nxt       = entry_advance(cur);
                        entry_nxt = {entry[PW_W-KEY_W-1:0], key_code};
                        dcnt_nxt  = digit_count + DCNT_W'(1);
                    end
                end
                S_UNLOCK: begin
                    if (key_enter) begin
                        nxt      = S_IDLE;
                        tmr_load = 1'b1;
`ifdef SAFE_PWCHANGE_EN
                    end else if (key_star) begin
                        nxt       = S_NEWPW;
                        entry_nxt = '0;
                        dcnt_nxt  = '0;
`endif
                    end else if (tmr_expired) begin
                        nxt = S_IDLE;
                    end
                end
                S_FAIL: begin
                    if (tmr_expired) begin
                        if (fail_count == FCNT_W'(MAX_FAIL)) begin
                            nxt       = S_LOCKOUT;
                            tmr_load  = 1'b1;
                            tmr_value = TMR_W'(LOCKOUT_MS - 1);
                        end else begin
                            nxt = S_IDLE;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (tmr_expired) begin
                        nxt      = S_IDLE;
                        fcnt_nxt = '0;
                    end
                end
                S_EMERGENCY: begin
                    nxt       = S_IDLE;
                    entry_nxt = '0;
                    dcnt_nxt  = '0;
                    fcnt_nxt  = '0;
                    tmr_load  = 1'b1;
                end
`ifdef SAFE_PWCHANGE_EN
                S_NEWPW: begin
                    if (key_enter) begin
                        if (digit_count == DCNT_W'(PW_DIGITS)) begin
                            nxt       = S_SAVED;
                            pw_we     = 1'b1;
                            entry_nxt = '0;
                            dcnt_nxt  = '0;
                            tmr_load  = 1'b1;
                            tmr_value = TMR_W'(FAIL_MS - 1);
                        end
                    end else if (key_clear) begin
                        nxt       = S_UNLOCK;
                        entry_nxt = '0;
                        dcnt_nxt  = '0;
                    end else if (key_digit && (digit_count != DCNT_W'(PW_DIGITS))) begin
                        entry_nxt = {entry[PW_W-KEY_W-1:0], key_code};
                        dcnt_nxt  = digit_count + DCNT_W'(1);
                    end
                end
                S_SAVED: begin
                    if (tmr_expired) begin
                        nxt = S_IDLE;
                    end
                end
`endif
                default: nxt = S_IDLE;
            endcase
        end
    end

    // All architectural state; door_unlock is registered from the next state.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            cur         <= S_IDLE;
            entry       <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            door_unlock <= 1'b0;
`ifdef SAFE_PWCHANGE_EN
            pw          <= DEFAULT_PW;
`endif
        end else begin
            cur         <= nxt;
            entry       <= entry_nxt;
            digit_count <= dcnt_nxt;
            fail_count  <= fcnt_nxt;
            door_unlock <= (nxt == S_UNLOCK) || (nxt == S_EMERGENCY);
`ifdef SAFE_PWCHANGE_EN
            if (pw_we) begin
                pw <= entry;
            end
`endif
        end
    end

endmodule
